// File: rtl/memory_dma.sv
// memory_dma: single-channel block-copy engine.
// Reads one word from the source pointer, writes it to the destination
// pointer, and repeats until the programmed word count is exhausted.
// Every request is guarded by a wait counter that aborts the transfer
// if the responder stays silent for TIMEOUT_CYCLES cycles.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; no request outstanding
// READ   | memory_read asserted at src pointer, waiting for response
// WRITE  | memory_write asserted at dst pointer, waiting for response
// FINISH | done pulse, back to IDLE next cycle
// ABORT  | error pulse after a timeout, back to IDLE next cycle
module memory_dma #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned LEN_WIDTH      = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [31:0]          i_src_addr,
    input  logic [31:0]          i_dst_addr,
    input  logic [LEN_WIDTH-1:0] i_length,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error,
    output logic [LEN_WIDTH-1:0] o_words_done,
    output logic                 o_memory_read,
    output logic                 o_memory_write,
    output logic [31:0]          o_address,
    output logic [31:0]          o_write_data,
    input  logic [31:0]          i_read_data,
    input  logic                 i_response
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_FINISH = 3'd3,
        ST_ABORT  = 3'd4
    } state_t;

    // Wait count at which a still-unanswered request is abandoned. A
    // response seen while the counter holds this value still completes.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    state_t               r_state;
    logic [31:0]          r_src_ptr;
    logic [31:0]          r_dst_ptr;
    logic [LEN_WIDTH-1:0] r_remaining;
    logic [LEN_WIDTH-1:0] r_words_done;
    logic [15:0]          r_wait;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;
    logic                 r_memory_read;
    logic                 r_memory_write;
    logic [31:0]          r_address;
    logic [31:0]          r_write_data;

    wire logic [31:0] w_src_aligned = {i_src_addr[31:2], 2'b00};
    wire logic [31:0] w_dst_aligned = {i_dst_addr[31:2], 2'b00};
    wire logic        w_wait_expired = (r_wait == WAIT_LAST);

    // Sequencing FSM; every output is loaded alongside the state it belongs to.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state        <= ST_IDLE;
            r_src_ptr      <= '0;
            r_dst_ptr      <= '0;
            r_remaining    <= '0;
            r_words_done   <= '0;
            r_wait         <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_memory_read  <= 1'b0;
            r_memory_write <= 1'b0;
            r_address      <= '0;
            r_write_data   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done  <= 1'b0;
                    r_error <= 1'b0;
                    if (i_start) begin
                        r_src_ptr    <= w_src_aligned;
                        r_dst_ptr    <= w_dst_aligned;
                        r_remaining  <= i_length;
                        r_words_done <= '0;
                        r_wait       <= '0;
                        r_busy       <= 1'b1;
                        if (i_length == '0) begin
                            r_state <= ST_FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_state       <= ST_READ;
                            r_memory_read <= 1'b1;
                            r_address     <= w_src_aligned;
                        end
                    end
                end

                ST_READ: begin
                    if (i_response) begin
                        r_state        <= ST_WRITE;
                        r_src_ptr      <= r_src_ptr + 32'd4;
                        r_write_data   <= i_read_data;
                        r_memory_read  <= 1'b0;
                        r_memory_write <= 1'b1;
                        r_address      <= r_dst_ptr;
                        r_wait         <= '0;
                    end else if (w_wait_expired) begin
                        r_state       <= ST_ABORT;
                        r_memory_read <= 1'b0;
                        r_address     <= '0;
                        r_error       <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 16'd1;
                    end
                end

                ST_WRITE: begin
                    if (i_response) begin
                        r_dst_ptr      <= r_dst_ptr + 32'd4;
                        r_words_done   <= r_words_done + LEN_ONE;
                        r_remaining    <= r_remaining - LEN_ONE;
                        r_memory_write <= 1'b0;
                        r_write_data   <= '0;
                        r_wait         <= '0;
                        if (r_remaining == LEN_ONE) begin
                            r_state   <= ST_FINISH;
                            r_done    <= 1'b1;
                            r_address <= '0;
                        end else begin
                            r_state       <= ST_READ;
                            r_memory_read <= 1'b1;
                            r_address     <= r_src_ptr;
                        end
                    end else if (w_wait_expired) begin
                        r_state        <= ST_ABORT;
                        r_memory_write <= 1'b0;
                        r_address      <= '0;
                        r_write_data   <= '0;
                        r_error        <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 16'd1;
                    end
                end

                ST_FINISH: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end

                ST_ABORT: begin
                    r_state <= ST_IDLE;
                    r_error <= 1'b0;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state        <= ST_IDLE;
                    r_busy         <= 1'b0;
                    r_done         <= 1'b0;
                    r_error        <= 1'b0;
                    r_memory_read  <= 1'b0;
                    r_memory_write <= 1'b0;
                    r_address      <= '0;
                    r_write_data   <= '0;
                end
            endcase
        end
    end

    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_error        = r_error;
    assign o_words_done   = r_words_done;
    assign o_memory_read  = r_memory_read;
    assign o_memory_write = r_memory_write;
    assign o_address      = r_address;
    assign o_write_data   = r_write_data;

endmodule

// File: doc/memory_dma.md
# memory_dma

Single-channel block-copy engine that acts as the initiator on the core's word-wide memory request interface (`memory_read` / `memory_write` / `address` / `write_data` / `read_data` / `response`). Software programs a source address, a destination address and a word count, then pulses `start`. The engine alternates read and write transactions against the memory-side responder until the block is copied, then reports `done`. A per-transaction timeout flags `error` if the responder never answers.

## Interface
**Parameters**
- `TIMEOUT_CYCLES`, default 255: cycles a request may stay unanswered before abort. Legal range 1..65535.
- `LEN_WIDTH`, default 16: width of the word-count field.

**Ports**
- `clk` input 1: system clock; all logic on posedge.
- `rst_n` input 1: reset, synchronous, active-low.
- `start` input 1: one-cycle request to begin a copy; sampled only in IDLE.
- `src_addr` input 32: byte address of the first source word; bits [1:0] ignored.
- `dst_addr` input 32: byte address of the first destination word; bits [1:0] ignored.
- `length` input LEN_WIDTH: number of 32-bit words to copy.
- `busy` output 1: high from the cycle after an accepted `start` until the engine returns to IDLE.
- `done` output 1: one-cycle pulse on normal completion.
- `error` output 1: one-cycle pulse on timeout abort.
- `words_done` output LEN_WIDTH: count of words written so far in the current or last transfer.
- `memory_read` output 1: read request.
- `memory_write` output 1: write request.
- `address` output 32: request address, always word-aligned (bits [1:0] = 0).
- `write_data` output 32: write payload.
- `read_data` input 32: read payload, valid while `response` is high during a read.
- `response` input 1: transaction-complete indication from the responder.

## Operation
- **States:** IDLE, READ, WRITE, FINISH, ABORT.
- **IDLE:**
  - All request outputs are 0.
  - On `start`, latch `{src[31:2],2'b00}`, `{dst[31:2],2'b00}` and `length`, and clear `words_done`.
  - If `length == 0`, go to FINISH; otherwise go to READ.
- **READ:**
  - Drive `memory_read = 1` and `address = src_ptr`.
  - On a cycle with `response == 1`, capture `read_data` into the data register, `src_ptr += 4`, and go to WRITE.
- **WRITE:**
  - Drive `memory_write = 1`, `address = dst_ptr` and `write_data = data register`.
  - On `response == 1`:
    - `dst_ptr += 4`, `words_done += 1`, remaining count `-= 1`.
    - If the remaining count reaches 0, go to FINISH; otherwise go to READ.
- **FINISH:** `done = 1` for one cycle, then go to IDLE.
- **ABORT:** `error = 1` for one cycle, then go to IDLE. `words_done` keeps the number of words completed before the abort.
- **Request rules:**
  - `memory_read` and `memory_write` are never high together.
  - A request stays asserted with a stable address and data until `response` is seen.
- **Timeout:**
  - The wait counter resets on entry to READ or WRITE and increments each cycle `response` stays low.
  - When the counter reaches `TIMEOUT_CYCLES`, drop the request and go to ABORT.
- **Pointer arithmetic:** pointers are 32-bit and wrap modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000).
- **Ignored inputs:** `start` is ignored outside IDLE, and `response` is ignored in IDLE, FINISH and ABORT.
- **Reset:** `rst_n` low at any clock edge forces IDLE, even mid-transfer. The request in flight is dropped, with no completion write.

## Timing
- **Reset values:**
  - `busy`, `done`, `error`, `memory_read` and `memory_write` are 0.
  - `address`, `write_data` and `words_done` are 0.
- **Outputs:** all outputs are registered or decoded from registered state; there is no combinational path from `response` or `read_data` to any output.
- **Start latency:** with `start` at edge N, the first `memory_read` is high in cycle N+1.
- **Zero-wait responder** (`response` equal to the request in the same cycle): each word takes 2 cycles, READ then WRITE. For L words, `busy` lasts 2L+1 cycles and `done` is high in the last of them.
- **Stalled responder:** each wait cycle extends the current state by one cycle.
- **Response within timeout:** a `response` arriving in the same cycle the counter would hit `TIMEOUT_CYCLES` wins, and the transaction completes.
- **Start after completion:** `start` can be accepted in the cycle after `done`/`error`, once the engine is back in IDLE.

## Test plan
- **Basic copy:** 4-word copy src=0x100, dst=0x200, zero-wait memory preloaded 0x11..0x44.
  - Writes appear to 0x200..0x20C with 0x11..0x44.
  - `busy` is high 9 cycles, `done` pulses in the 9th, `words_done = 4`.
- **Zero length:** `length = 0`. No request is issued; `done` pulses 1 cycle after `start` and `busy` is high 1 cycle.
- **Unaligned addresses and stalls:** src=0x103, dst=0x206, length 2, responder delays `response` 3 cycles per transaction.
  - Addresses used are 0x100, 0x204, 0x104, 0x208.
  - Total busy time is 2·2·4 + 1 = 17 cycles.
- **Timeout:** responder never responds, `TIMEOUT_CYCLES = 8`. `memory_read` drops after 8 cycles, `error` pulses, `done` never pulses, `words_done = 0`.
- **Start while busy:** a second `start` with different addresses mid-transfer is ignored; the original block is copied intact.
- **Reset mid-transfer:** `rst_n` low during WRITE of word 2 of 5.
  - The next cycle shows all outputs at reset values, with no further requests.
  - A new `start` then copies correctly.
